// File: rtl/reg_file_pkg.sv
// Shared types and constants for the parametrised register file.
// Holds the clear-sweep state encoding and the default geometry.
package reg_file_pkg;

    typedef enum logic {
        IDLE,
        CLEARING
    } clr_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int MAX_DATA_W = 256;

    // Callers narrow this to their own width with a size cast.
    function automatic logic [MAX_DATA_W-1:0] zero_data();
        return '0;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bus bundle for the register file: one write port, two read ports and the clear controls.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              CLEAR;
    logic              BUSY;
    logic              WR_DROP;

    modport master (
        output WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        input  OUT1, OUT2, BUSY, WR_DROP
    );

    modport slave (
        input  WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        output OUT1, OUT2, BUSY, WR_DROP
    );

endinterface

// File: rtl/reg_file_clear_ctrl.sv
// Bulk-clear sequencer: sweeps every register to zero one per cycle and
// rejects writes while the sweep runs, reporting each rejection a cycle later.
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              write,
    output logic              busy,
    output logic              wr_drop,
    output logic              write_ok,
    output logic              clr_strobe,
    output logic [ADDR_W-1:0] clr_index
);

    localparam int DEPTH = 1 << ADDR_W;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] index_nxt;
    logic              drop_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            clr_index <= '0;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_index <= index_nxt;
            wr_drop   <= drop_nxt;
        end
    end

    // A CLEAR seen in IDLE still lets that edge's write through; the sweep
    // starts on the following edge and ignores further CLEAR requests.
    always_comb begin
        state_nxt  = state;
        index_nxt  = clr_index;
        drop_nxt   = 1'b0;
        write_ok   = 1'b0;
        clr_strobe = 1'b0;
        case (state)
            IDLE: begin
                write_ok = write;
                if (clear) begin
                    state_nxt = CLEARING;
                    index_nxt = '0;
                end
            end
            CLEARING: begin
                clr_strobe = 1'b1;
                drop_nxt   = write;
                index_nxt  = clr_index + 1'b1;
                if (clr_index == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == CLEARING);

endmodule

// File: rtl/reg_file_param.sv
// Parametrised two-read/one-write register file with optional zero register,
// registered reads, write-to-read forwarding and a sequenced bulk clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic     CLK,
    input  logic     RESET,
    reg_file_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_ok;
    logic              write_commit;
    logic              clr_strobe;
    logic [ADDR_W-1:0] clr_index;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    reg_file_clear_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_clear_ctrl (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (bus.CLEAR),
        .write     (bus.WRITE),
        .busy      (bus.BUSY),
        .wr_drop   (bus.WR_DROP),
        .write_ok  (write_ok),
        .clr_strobe(clr_strobe),
        .clr_index (clr_index)
    );

    // Writes aimed at a hardwired-zero r0 are accepted but simply not stored.
    assign write_commit = write_ok && !((R0_ZERO != 0) && (bus.INADDRESS == '0));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_strobe) begin
            regs[clr_index] <= '0;
        end else if (write_commit) begin
            regs[bus.INADDRESS] <= bus.IN;
        end
    end

    // Forwarding only happens for an accepted write, so it is off during a sweep.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wok,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if ((R0_ZERO != 0) && (addr == '0)) begin
            return DATA_W'(zero_data());
        end
        if ((BYPASS != 0) && wok && (addr == waddr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rd1 = read_port(bus.OUT1ADDRESS, regs[bus.OUT1ADDRESS], write_ok,
                           bus.INADDRESS, bus.IN);
    assign rd2 = read_port(bus.OUT2ADDRESS, regs[bus.OUT2ADDRESS], write_ok,
                           bus.INADDRESS, bus.IN);

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] out1_q;
            logic [DATA_W-1:0] out2_q;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    out1_q <= '0;
                    out2_q <= '0;
                end else begin
                    out1_q <= rd1;
                    out2_q <= rd2;
                end
            end

            assign bus.OUT1 = out1_q;
            assign bus.OUT2 = out2_q;
        end else begin : g_read_comb
            assign bus.OUT1 = rd1;
            assign bus.OUT2 = rd2;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: four configurations share one stimulus stream and
// are compared against an array-based model of the register file.
module tb_reg_file_param;

    // Instance g: READ_REG=RR_V[g], BYPASS=BP_V[g], R0_ZERO=Z_V[g]
    localparam logic [3:0] RR_V = 4'b1100;
    localparam logic [3:0] BP_V = 4'b0101;
    localparam logic [3:0] Z_V  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       clear;
    logic [2:0] waddr;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] wdata;

    logic [7:0] out1 [4];
    logic [7:0] out2 [4];
    logic       busyS [4];
    logic       dropS [4];

    logic [7:0] mregs [4][8];
    logic [7:0] mq1 [4];
    logic [7:0] mq2 [4];
    int         clearLeft;
    int         clearIdx;
    logic       mdrop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : gi
            reg_file_if #(.DATA_W(8), .ADDR_W(3)) b ();

            assign b.WRITE       = write;
            assign b.INADDRESS   = waddr;
            assign b.IN          = wdata;
            assign b.OUT1ADDRESS = a1;
            assign b.OUT2ADDRESS = a2;
            assign b.CLEAR       = clear;

            reg_file_param #(
                .DATA_W  (8),
                .ADDR_W  (3),
                .READ_REG(RR_V[g] ? 1 : 0),
                .BYPASS  (BP_V[g] ? 1 : 0),
                .R0_ZERO (Z_V[g] ? 1 : 0)
            ) dut (
                .CLK  (clk),
                .RESET(rst),
                .bus  (b)
            );

            assign out1[g]  = b.OUT1;
            assign out2[g]  = b.OUT2;
            assign busyS[g] = b.BUSY;
            assign dropS[g] = b.WR_DROP;
        end
    endgenerate

    function automatic logic [7:0] expRead(int g, logic [2:0] addr);
        if (Z_V[g] && addr == 3'd0) return 8'd0;
        if (BP_V[g] && write && clearLeft == 0 && addr == waddr) return wdata;
        return mregs[g][addr];
    endfunction

    task automatic modelReset();
        for (int g = 0; g < 4; g++) begin
            for (int r = 0; r < 8; r++) mregs[g][r] = 8'd0;
            mq1[g] = 8'd0;
            mq2[g] = 8'd0;
        end
        clearLeft = 0;
        clearIdx  = 0;
        mdrop     = 1'b0;
    endtask

    task automatic modelEdge();
        logic [7:0] n1 [4];
        logic [7:0] n2 [4];
        for (int g = 0; g < 4; g++) begin
            n1[g] = expRead(g, a1);
            n2[g] = expRead(g, a2);
        end
        mdrop = write && (clearLeft > 0);
        if (clearLeft > 0) begin
            for (int g = 0; g < 4; g++) mregs[g][clearIdx] = 8'd0;
            clearIdx  = (clearIdx + 1) % 8;
            clearLeft = clearLeft - 1;
        end else begin
            if (write) begin
                for (int g = 0; g < 4; g++) begin
                    if (!(Z_V[g] && waddr == 3'd0)) mregs[g][waddr] = wdata;
                end
            end
            if (clear) begin
                clearLeft = 8;
                clearIdx  = 0;
            end
        end
        for (int g = 0; g < 4; g++) begin
            mq1[g] = n1[g];
            mq2[g] = n2[g];
        end
    endtask

    task automatic checkOne(string tag, int g, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s[%0d] observed %0h expected %0h", tag, g, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int g = 0; g < 4; g++) begin
            checkOne("out1", g, out1[g], RR_V[g] ? mq1[g] : expRead(g, a1));
            checkOne("out2", g, out2[g], RR_V[g] ? mq2[g] : expRead(g, a2));
            checkOne("busy", g, 8'(busyS[g]), 8'(clearLeft > 0));
            checkOne("wr_drop", g, 8'(dropS[g]), 8'(mdrop));
        end
    endtask

    task automatic applyStimulus(logic w, logic [2:0] wa, logic [7:0] wd,
                                 logic [2:0] r1, logic [2:0] r2, logic c);
        @(negedge clk);
        write = w;
        waddr = wa;
        wdata = wd;
        a1    = r1;
        a2    = r2;
        clear = c;
        #1;
        checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelEdge();
    endtask

    initial begin
        rst   = 1'b1;
        write = 1'b0;
        clear = 1'b0;
        waddr = 3'd0;
        wdata = 8'd0;
        a1    = 3'd0;
        a2    = 3'd0;
        modelReset();
        #3;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        clockEdge();

        // Basic writes then reads with no added latency on combinational ports
        applyStimulus(1'b1, 3'd1, 8'd42, 3'd1, 3'd3, 1'b0); clockEdge();
        applyStimulus(1'b1, 3'd3, 8'd14, 3'd1, 3'd3, 1'b0); clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd1, 3'd3, 1'b0);
        checkOne("plan_r1", 0, out1[0], 8'd42);
        checkOne("plan_r3", 0, out2[0], 8'd14);
        checkOne("plan_r1", 1, out1[1], 8'd42);
        clockEdge();

        // Forwarding versus no forwarding on combinational ports
        applyStimulus(1'b1, 3'd5, 8'd46, 3'd5, 3'd0, 1'b0);
        checkOne("bypass_on", 0, out1[0], 8'd46);
        checkOne("bypass_off", 1, out1[1], 8'd0);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd5, 3'd7, 1'b0);
        checkOne("bypass_off_after", 1, out1[1], 8'd46);
        clockEdge();

        // Registered ports: one edge with forwarding, two without
        applyStimulus(1'b1, 3'd7, 8'd62, 3'd5, 3'd7, 1'b0); clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd5, 3'd7, 1'b0);
        checkOne("rreg_bypass", 2, out2[2], 8'd62);
        checkOne("rreg_nobypass_n", 3, out2[3], 8'd0);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd5, 3'd7, 1'b0);
        checkOne("rreg_nobypass_n1", 3, out2[3], 8'd62);
        clockEdge();

        // Fill, then sweep with a write attempt in the middle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'(i + 1), 3'd0, 3'd0, 1'b0); clockEdge();
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
        checkOne("busy_before", 0, 8'(busyS[0]), 8'd0);
        clockEdge();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(k == 2, 3'd2, 8'd99, 3'(k), 3'(k - 1), 1'b0);
            checkOne("sweep_busy", 0, 8'(busyS[0]), 8'd1);
            checkOne("sweep_pending", 0, out1[0], 8'(k + 1));
            if (k > 0) checkOne("sweep_cleared", 0, out2[0], 8'd0);
            if (k == 3) checkOne("drop_pulse", 0, 8'(dropS[0]), 8'd1);
            clockEdge();
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd2, 3'd0, 1'b0);
        checkOne("busy_after", 0, 8'(busyS[0]), 8'd0);
        checkOne("r2_after_drop", 0, out1[0], 8'd0);
        checkOne("drop_one_cycle", 0, 8'(dropS[0]), 8'd0);
        clockEdge();

        // Asynchronous reset in the middle of a sweep
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'(i * 16 + 3), 3'd6, 3'd7, 1'b0); clockEdge();
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd6, 3'd7, 1'b1); clockEdge();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'd0, 8'd0, 3'd6, 3'd7, 1'b0); clockEdge();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkOne("rst_busy", 0, 8'(busyS[0]), 8'd0);
        checkOne("rst_out1", 0, out1[0], 8'd0);
        checkOne("rst_out2_reg", 2, out2[2], 8'd0);
        #1 rst = 1'b0;
        clockEdge();
        applyStimulus(1'b1, 3'd0, 8'h11, 3'd0, 3'd4, 1'b0); clockEdge();
        applyStimulus(1'b1, 3'd4, 8'h44, 3'd0, 3'd4, 1'b0); clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b1); clockEdge();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b0);
            checkOne("restart_busy", 1, 8'(busyS[1]), 8'd1);
            clockEdge();
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b0);
        checkOne("restart_done", 1, 8'(busyS[1]), 8'd0);
        clockEdge();

        // Hardwired-zero r0 on instance 3
        applyStimulus(1'b1, 3'd0, 8'd255, 3'd0, 3'd0, 1'b0);
        checkOne("r0_zero_bypass", 3, out1[3], 8'd0);
        checkOne("r0_normal_bypass", 0, out1[0], 8'd255);
        clockEdge();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0);
        checkOne("r0_zero_read", 3, out1[3], 8'd0);
        checkOne("r0_no_drop", 3, 8'(dropS[3]), 8'd0);
        checkOne("r0_normal_read", 0, out1[0], 8'd255);
        clockEdge();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          8'($urandom), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), $urandom_range(0, 24) == 0);
            clockEdge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
